// File: rtl/camera_frame_writer_pkg.sv
// Purpose : shared types and widths for the camera frame writer.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package camera_frame_writer_pkg;

  typedef enum logic {
    WAIT_SOF = 1'b0,
    CAPTURE  = 1'b1
  } cfw_state_t;

  localparam int PIX_IDX_W = 19;  // pixel index inside a frame buffer
  localparam int ADDR_W    = 25;  // SDRAM word address
  localparam int PIX_W     = 10;  // camera pixel width

endpackage

// File: rtl/cfw_test_pattern.sv
// Purpose : test-pattern data source; tracks column/line of the pixel being written and
//           replaces camera data with {pix_idx[4:0] ^ line[4:0]} when test_sel is set.
// Latency : combinational data path; line/column state updates on each accepted pixel.
// Backpressure: none; follows the writer's accept strobe.
// Ports: take (pixel accepted), restart (this pixel is pixel 0), clear (this pixel ends
//        the frame), pix_lsb (low bits of the pixel index), cam_data in, din out.
// Only built when CAM_TEST_PATTERN_EN is defined.
`ifdef CAM_TEST_PATTERN_EN
module cfw_test_pattern
  import camera_frame_writer_pkg::*;
#(
  parameter int FRAME_W = 640,
  parameter int FRAME_H = 480
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             take,
  input  logic             restart,
  input  logic             clear,
  input  logic             test_sel,
  input  logic [4:0]       pix_lsb,
  input  logic [PIX_W-1:0] cam_data,
  output logic [PIX_W-1:0] din
);

  logic [PIX_IDX_W-1:0] col, line;
  logic [PIX_IDX_W-1:0] cur_col, cur_line;

  // Position of the pixel being written this cycle (restart forces pixel 0).
  assign cur_col  = restart ? '0 : col;
  assign cur_line = restart ? '0 : line;

  assign din = test_sel ? {{(PIX_W-5){1'b0}}, pix_lsb ^ cur_line[4:0]} : cam_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col  <= '0;
      line <= '0;
    end else if (take) begin
      if (clear) begin
        col  <= '0;
        line <= '0;
      end else if (cur_col == PIX_IDX_W'(FRAME_W - 1)) begin
        col  <= '0;
        line <= (cur_line == PIX_IDX_W'(FRAME_H - 1)) ? '0 : cur_line + PIX_IDX_W'(1);
      end else begin
        col  <= cur_col + PIX_IDX_W'(1);
        line <= cur_line;
      end
    end else if (restart) begin
      col  <= '0;
      line <= '0;
    end
  end

endmodule
`endif

// File: rtl/camera_frame_writer.sv
// Purpose : writes a camera pixel stream into one of two SDRAM frame buffers via port C,
//           swapping buffers and publishing the finished one as the display base per frame.
// Latency : 1 cycle from accepted cam_valid to portC_write/addr/din; status in the same cycle.
// Backpressure: none; every accepted pixel is written, the writer never stalls.
// Ports: clk, rst_n (async active-low); capture_en, cam_sof, cam_valid, cam_data in;
//        portC_write/addr/din out; disp_base, frame_done, frame_err, frame_count, err_count out.
// Option: CAM_TEST_PATTERN_EN adds input test_sel selecting a generated test pattern.
module camera_frame_writer
  import camera_frame_writer_pkg::*;
#(
  parameter int                FRAME_W   = 640,
  parameter int                FRAME_H   = 480,
  parameter logic [ADDR_W-1:0] BUF0_BASE = 25'd0,
  parameter logic [ADDR_W-1:0] BUF1_BASE = 25'd524288
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef CAM_TEST_PATTERN_EN
  input  logic              test_sel,
`endif
  input  logic              capture_en,
  input  logic              cam_sof,
  input  logic              cam_valid,
  input  logic [PIX_W-1:0]  cam_data,
  output logic              portC_write,
  output logic [ADDR_W-1:0] portC_addr,
  output logic [PIX_W-1:0]  portC_din,
  output logic [ADDR_W-1:0] disp_base,
  output logic              frame_done,
  output logic              frame_err,
  output logic [15:0]       frame_count,
  output logic [7:0]        err_count
);

  localparam logic [PIX_IDX_W-1:0] LAST_IDX = PIX_IDX_W'(FRAME_W * FRAME_H - 1);

  cfw_state_t           state;
  logic                 wr_sel;   // 0: writing buffer 0, 1: writing buffer 1
  logic [PIX_IDX_W-1:0] pix_idx;
  logic [ADDR_W-1:0]    wr_base;
  logic                 start, abort, take, last;
  logic [PIX_IDX_W-1:0] eff_idx;
  logic [PIX_W-1:0]     din_next;

  assign wr_base = wr_sel ? BUF1_BASE : BUF0_BASE;
  assign start   = (state == WAIT_SOF) && cam_sof && capture_en;
  // Any sof inside a frame is premature: reaching the last pixel already left CAPTURE.
  assign abort   = (state == CAPTURE) && cam_sof;
  assign take    = cam_valid && ((state == CAPTURE) || start);
  // A sof (start or abort) makes the same-cycle pixel pixel 0, so sof beats "last pixel".
  assign eff_idx = (start || abort) ? '0 : pix_idx;
  assign last    = take && (eff_idx == LAST_IDX);

`ifdef CAM_TEST_PATTERN_EN
  cfw_test_pattern #(
    .FRAME_W(FRAME_W),
    .FRAME_H(FRAME_H)
  ) u_test_pattern (
    .clk      (clk),
    .rst_n    (rst_n),
    .take     (take),
    .restart  (start || abort),
    .clear    (last),
    .test_sel (test_sel),
    .pix_lsb  (eff_idx[4:0]),
    .cam_data (cam_data),
    .din      (din_next)
  );
`else
  assign din_next = cam_data;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= WAIT_SOF;
      wr_sel      <= 1'b0;
      pix_idx     <= '0;
      portC_write <= 1'b0;
      portC_addr  <= '0;
      portC_din   <= '0;
      disp_base   <= BUF1_BASE;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      frame_count <= '0;
      err_count   <= '0;
    end else begin
      portC_write <= take;
      frame_done  <= last;
      frame_err   <= abort;
      if (take) begin
        portC_addr <= wr_base + ADDR_W'(eff_idx);
        portC_din  <= din_next;
      end

      if (last) begin
        state       <= WAIT_SOF;
        pix_idx     <= '0;
        disp_base   <= wr_base;
        wr_sel      <= ~wr_sel;
        frame_count <= frame_count + 16'd1;
      end else if (take) begin
        state   <= CAPTURE;
        pix_idx <= eff_idx + PIX_IDX_W'(1);
      end else if (start || abort) begin
        state   <= CAPTURE;
        pix_idx <= '0;
      end

      if (abort && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_camera_frame_writer.sv
// Purpose : self-checking bench for camera_frame_writer (4x2 frames, buffers at 0 and 16).
// Latency : expects port C writes one cycle after each accepted pixel.
// Backpressure: none exercised; the DUT has no stall path.
module tb_camera_frame_writer;

  typedef struct packed {
    logic [24:0] addr;
    logic [9:0]  din;
    logic        done;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
`ifdef CAM_TEST_PATTERN_EN
  logic        test_sel;
`endif
  logic        capture_en;
  logic        cam_sof;
  logic        cam_valid;
  logic [9:0]  cam_data;
  logic        portC_write;
  logic [24:0] portC_addr;
  logic [9:0]  portC_din;
  logic [24:0] disp_base;
  logic        frame_done;
  logic        frame_err;
  logic [15:0] frame_count;
  logic [7:0]  err_count;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  camera_frame_writer #(
    .FRAME_W   (4),
    .FRAME_H   (2),
    .BUF0_BASE (25'd0),
    .BUF1_BASE (25'd16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef CAM_TEST_PATTERN_EN
    .test_sel    (test_sel),
`endif
    .capture_en  (capture_en),
    .cam_sof     (cam_sof),
    .cam_valid   (cam_valid),
    .cam_data    (cam_data),
    .portC_write (portC_write),
    .portC_addr  (portC_addr),
    .portC_din   (portC_din),
    .disp_base   (disp_base),
    .frame_done  (frame_done),
    .frame_err   (frame_err),
    .frame_count (frame_count),
    .err_count   (err_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expw(input logic [24:0] addr, input logic [9:0] din,
                      input logic done, input logic err);
    exp_t e;
    e.addr = addr; e.din = din; e.done = done; e.err = err;
    exp_q.push_back(e);
  endtask

  // One stimulus cycle; inputs change 1 time unit after a rising edge.
  task automatic cyc(input logic sof, input logic valid, input logic [9:0] data);
    cam_sof = sof; cam_valid = valid; cam_data = data;
    @(posedge clk); #1;
    cam_sof = 1'b0; cam_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 10'd0);
  endtask

  // Monitor: every write pops the next expected entry; status pulses without a write are errors.
  always @(negedge clk) begin
    if (portC_write) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: addr 0x%0h din 0x%0h, none expected", portC_addr, portC_din);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(portC_addr), 32'(e.addr));
        chk("wr_din", 32'(portC_din), 32'(e.din));
        chk("wr_done", 32'(frame_done), 32'(e.done));
        chk("wr_err", 32'(frame_err), 32'(e.err));
      end
    end else if (frame_done || frame_err) begin
      checks++; errors++;
      $display("FAIL pulse_without_write: done %0b err %0b expected 0 0", frame_done, frame_err);
    end
  end

  initial begin
    int gap;
    logic [9:0] pat [8];
    pat[0] = 10'd0; pat[1] = 10'd1; pat[2] = 10'd2; pat[3] = 10'd3;
    pat[4] = 10'd5; pat[5] = 10'd4; pat[6] = 10'd7; pat[7] = 10'd6;

    rst_n = 1'b0; capture_en = 1'b1; cam_sof = 1'b0; cam_valid = 1'b0; cam_data = '0;
`ifdef CAM_TEST_PATTERN_EN
    test_sel = 1'b0;
`endif
    #12;
    chk("rst_write", 32'(portC_write), 32'd0);
    chk("rst_disp_base", 32'(disp_base), 32'd16);
    chk("rst_frame_count", 32'(frame_count), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_addr", 32'(portC_addr), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Full frame into buffer 0, then into buffer 16.
    expw(25'd0, 10'd1, 1'b0, 1'b0); cyc(1'b1, 1'b1, 10'd1);
    for (int k = 1; k < 8; k++) begin
      expw(25'(k), 10'(k + 1), (k == 7), 1'b0); cyc(1'b0, 1'b1, 10'(k + 1));
    end
    chk("f1_disp_base", 32'(disp_base), 32'd0);
    chk("f1_frame_count", 32'(frame_count), 32'd1);
    idle(1);
    expw(25'd16, 10'd9, 1'b0, 1'b0); cyc(1'b1, 1'b1, 10'd9);
    for (int k = 1; k < 8; k++) begin
      expw(25'(16 + k), 10'(9 + k), (k == 7), 1'b0); cyc(1'b0, 1'b1, 10'(9 + k));
    end
    chk("f2_disp_base", 32'(disp_base), 32'd16);
    chk("f2_frame_count", 32'(frame_count), 32'd2);
    idle(1);

    // Short frame: 3 pixels then sof+valid restarts in the same buffer.
    expw(25'd0, 10'd21, 1'b0, 1'b0); cyc(1'b1, 1'b1, 10'd21);
    expw(25'd1, 10'd22, 1'b0, 1'b0); cyc(1'b0, 1'b1, 10'd22);
    expw(25'd2, 10'd23, 1'b0, 1'b0); cyc(1'b0, 1'b1, 10'd23);
    expw(25'd0, 10'd24, 1'b0, 1'b1); cyc(1'b1, 1'b1, 10'd24);
    chk("short_err_count", 32'(err_count), 32'd1);
    chk("short_disp_base", 32'(disp_base), 32'd16);
    for (int k = 1; k < 8; k++) begin
      expw(25'(k), 10'(24 + k), (k == 7), 1'b0); cyc(1'b0, 1'b1, 10'(24 + k));
    end
    chk("short_then_full_disp", 32'(disp_base), 32'd0);
    chk("short_then_full_count", 32'(frame_count), 32'd3);
    idle(1);

    // Junk before sof, and sof while capture disabled: nothing is written.
    cyc(1'b0, 1'b1, 10'd33);
    cyc(1'b0, 1'b1, 10'd34);
    capture_en = 1'b0;
    cyc(1'b1, 1'b1, 10'd35);
    cyc(1'b0, 1'b1, 10'd36);
    idle(1);
    chk("junk_queue_empty", 32'(exp_q.size()), 32'd0);
    capture_en = 1'b1;
    expw(25'd16, 10'd40, 1'b0, 1'b0); cyc(1'b1, 1'b1, 10'd40);
    for (int k = 1; k < 8; k++) begin
      if (k == 2) capture_en = 1'b0;
      expw(25'(16 + k), 10'(40 + k), (k == 7), 1'b0); cyc(1'b0, 1'b1, 10'(40 + k));
    end
    chk("en_drop_count", 32'(frame_count), 32'd4);
    chk("en_drop_disp", 32'(disp_base), 32'd16);
    capture_en = 1'b1;
    idle(1);

    // Random idle gaps inside a frame (buffer 0).
    expw(25'd0, 10'd50, 1'b0, 1'b0); cyc(1'b1, 1'b1, 10'd50);
    for (int k = 1; k < 8; k++) begin
      gap = $urandom_range(0, 2);
      idle(gap);
      expw(25'(k), 10'(50 + k), (k == 7), 1'b0); cyc(1'b0, 1'b1, 10'(50 + k));
    end
    chk("gap_count", 32'(frame_count), 32'd5);
    chk("gap_disp", 32'(disp_base), 32'd0);
    idle(1);

    // sof coincident with what would be the last pixel: abort, pixel lands at wr_base.
    expw(25'd16, 10'd60, 1'b0, 1'b0); cyc(1'b1, 1'b1, 10'd60);
    for (int k = 1; k < 7; k++) begin
      expw(25'(16 + k), 10'(60 + k), 1'b0, 1'b0); cyc(1'b0, 1'b1, 10'(60 + k));
    end
    expw(25'd16, 10'd70, 1'b0, 1'b1); cyc(1'b1, 1'b1, 10'd70);
    chk("coincident_err_count", 32'(err_count), 32'd2);
    chk("coincident_count", 32'(frame_count), 32'd5);
    for (int k = 1; k < 8; k++) begin
      expw(25'(16 + k), 10'(70 + k), (k == 7), 1'b0); cyc(1'b0, 1'b1, 10'(70 + k));
    end
    chk("coincident_then_full_disp", 32'(disp_base), 32'd16);
    idle(1);

    // 256 back-to-back aborts: err_count saturates at 255.
    expw(25'd0, 10'd80, 1'b0, 1'b0); cyc(1'b1, 1'b1, 10'd80);
    for (int k = 0; k < 256; k++) begin
      expw(25'd0, 10'(k[7:0]), 1'b0, 1'b1); cyc(1'b1, 1'b1, 10'(k[7:0]));
    end
    chk("sat_err_count", 32'(err_count), 32'd255);
    for (int k = 1; k < 8; k++) begin
      expw(25'(k), 10'(90 + k), (k == 7), 1'b0); cyc(1'b0, 1'b1, 10'(90 + k));
    end
    chk("sat_then_full_count", 32'(frame_count), 32'd7);
    chk("sat_then_full_disp", 32'(disp_base), 32'd0);
    idle(1);

`ifdef CAM_TEST_PATTERN_EN
    // Test pattern: din = idx[4:0] ^ line[4:0], addresses unchanged (buffer 16).
    test_sel = 1'b1;
    expw(25'd16, pat[0], 1'b0, 1'b0); cyc(1'b1, 1'b1, 10'h3FF);
    for (int k = 1; k < 8; k++) begin
      expw(25'(16 + k), pat[k], (k == 7), 1'b0); cyc(1'b0, 1'b1, 10'h3FF);
    end
    chk("pattern_disp", 32'(disp_base), 32'd16);
    test_sel = 1'b0;
    idle(1);
`endif

    // Asynchronous reset mid-frame, while a write strobe is high.
    expw(25'(disp_base == 25'd0 ? 16 : 0), 10'd100, 1'b0, 1'b0); cyc(1'b1, 1'b1, 10'd100);
    expw(25'(disp_base == 25'd0 ? 17 : 1), 10'd101, 1'b0, 1'b0); cyc(1'b0, 1'b1, 10'd101);
    cyc(1'b0, 1'b1, 10'd102);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_write", 32'(portC_write), 32'd0);
    chk("arst_disp_base", 32'(disp_base), 32'd16);
    chk("arst_frame_count", 32'(frame_count), 32'd0);
    chk("arst_err_count", 32'(err_count), 32'd0);
    chk("arst_addr", 32'(portC_addr), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    expw(25'd0, 10'd7, 1'b0, 1'b0); cyc(1'b1, 1'b1, 10'd7);
    idle(2);
    chk("post_rst_err_count", 32'(err_count), 32'd0);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
